// File: rtl/sync_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ext
// Description : Single-clock FIFO with status flags, sticky errors, optional FWFT.
// Revision    : 1.0
// ============================================================================
module sync_fifo_ext #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 128,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic                    err_clr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  data_cnt,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]    cnt_q, cnt_d;
    logic                  full_q, empty_q, af_q, ae_q;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  w_wr_acc, w_rd_acc;

    // Acceptance uses the registered flags seen in this cycle.
    assign w_wr_acc = wr_en & ~full_q;
    assign w_rd_acc = rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_wr_acc) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        if (w_rd_acc) rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        // The wrap bit makes the modular difference span 0..DEPTH.
        cnt_d = wr_ptr_d - rd_ptr_d;
        ovf_d = (wr_en & full_q)  | (ovf_q & ~err_clr);
        unf_d = (rd_en & empty_q) | (unf_q & ~err_clr);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == c_PTR_W'(DEPTH));
            empty_q  <= (cnt_d == '0);
            af_q     <= (cnt_d >= c_PTR_W'(AF_LEVEL));
            ae_q     <= (cnt_d <= c_PTR_W'(AE_LEVEL));
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr_acc && !sys_rst) mem[wr_ptr_q[c_ADDR_W-1:0]] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic [c_ADDR_W-1:0]   w_head_addr;
            logic [DATA_WIDTH-1:0] w_head;

            // The next head is still in flight when it is the word written this edge.
            assign w_head_addr = rd_ptr_d[c_ADDR_W-1:0];
            assign w_head = (w_wr_acc && (w_head_addr == wr_ptr_q[c_ADDR_W-1:0]))
                          ? wr_data : mem[w_head_addr];

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= '0;
                end else begin
                    rd_valid_q <= (cnt_d != '0);
                    if (cnt_d != '0) rd_data_q <= w_head;
                end
            end
        end else begin : g_std
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= '0;
                end else begin
                    rd_valid_q <= w_rd_acc;
                    if (w_rd_acc) rd_data_q <= mem[rd_ptr_q[c_ADDR_W-1:0]];
                end
            end
        end
    endgenerate

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign data_cnt     = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
`default_nettype wire
